expr_string_tx: RTL

//  Transmit side of the ASCII arithmetic-expression stream (digit {op digit}).

---
 rtl/expr_string_tx_if.sv | 24 ++
 rtl/expr_string_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/expr_string_tx_if.sv
// Token-in / ASCII-byte-out handshake bundle for the expression-string transmitter.
// master drives tokens and accepts bytes; slave is the transmitter itself.
interface expr_string_tx_if;
    logic       tok_valid;
    logic       tok_ready;
    logic [3:0] tok_digit;
    logic       tok_op;
    logic       tok_last;
    logic [7:0] ch;
    logic       ch_valid;
    logic       ch_ready;
    logic       done;
    logic       err;

    modport master (
        output tok_valid, tok_digit, tok_op, tok_last, ch_ready,
        input  tok_ready, ch, ch_valid, done, err
    );

    modport slave (
        input  tok_valid, tok_digit, tok_op, tok_last, ch_ready,
        output tok_ready, ch, ch_valid, done, err
    );
endinterface

// File: rtl/expr_string_tx.sv
// Serialises operand tokens into an ASCII expression stream "d{op d}", one byte per handshake.
// Latency: token accept to first byte valid is 1 cycle; build with EXPR_TERM_EN to append TERM_CHAR.
// Backpressure: byte held stable until ch_ready; tokens accepted only while idle between operands.
module expr_string_tx #(
    parameter int unsigned MAX_OPS = 16
`ifdef EXPR_TERM_EN
    , parameter logic [7:0] TERM_CHAR = 8'h3D
`endif
) (
    input  logic                  clk,
    input  logic                  clr_n,
    expr_string_tx_if.slave       bus
);

    localparam logic [7:0] MAX_OPS_B = 8'(MAX_OPS);
    localparam logic [7:0] CH_BAD    = 8'h3F;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_MUL    = 8'h2A;

`ifdef EXPR_TERM_EN
    typedef enum logic [1:0] {IDLE, DIG, OP, TERM} state_t;
`else
    typedef enum logic [1:0] {IDLE, DIG, OP} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] ch_q, ch_d;
    logic       vld_q, vld_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] op_cnt_q, op_cnt_d;
    logic       op_q, op_d;
    logic       last_q, last_d;

    logic       illegal;
    logic       forced;

    assign illegal = (bus.tok_digit > 4'd9);
    // The operand that would reach MAX_OPS closes the expression whatever tok_last says.
    assign forced  = ((op_cnt_q + 8'd1) == MAX_OPS_B);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            ch_q     <= 8'h00;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            op_cnt_q <= 8'd0;
            op_q     <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            err_q    <= err_d;
            op_cnt_q <= op_cnt_d;
            op_q     <= op_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        vld_d    = vld_q;
        done_d   = 1'b0;
        err_d    = err_q;
        op_cnt_d = op_cnt_q;
        op_d     = op_q;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                if (bus.tok_valid) begin
                    state_d = DIG;
                    vld_d   = 1'b1;
                    ch_d    = illegal ? CH_BAD : {4'h3, bus.tok_digit};
                    op_d    = bus.tok_op;
                    last_d  = bus.tok_last | forced;
                    if (op_cnt_q == 8'd0) begin
                        err_d = 1'b0;
                    end
                    if (illegal || (forced && !bus.tok_last)) begin
                        err_d = 1'b1;
                    end
                end
            end
            DIG: begin
                if (bus.ch_ready) begin
                    op_cnt_d = op_cnt_q + 8'd1;
                    if (last_q) begin
`ifdef EXPR_TERM_EN
                        state_d = TERM;
                        ch_d    = TERM_CHAR;
`else
                        state_d  = IDLE;
                        vld_d    = 1'b0;
                        done_d   = 1'b1;
                        op_cnt_d = 8'd0;
`endif
                    end else begin
                        state_d = OP;
                        ch_d    = op_q ? CH_MUL : CH_PLUS;
                    end
                end
            end
            OP: begin
                if (bus.ch_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
`ifdef EXPR_TERM_EN
            TERM: begin
                if (bus.ch_ready) begin
                    state_d  = IDLE;
                    vld_d    = 1'b0;
                    done_d   = 1'b1;
                    op_cnt_d = 8'd0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    assign bus.tok_ready = (state_q == IDLE);
    assign bus.ch        = ch_q;
    assign bus.ch_valid  = vld_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
